// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared constants and types for the buzzer tone generator.
//   - NOTE_W / CNT_W      : note vector width and half-period counter width
//   - HP_DO .. HP_TI      : base half-period of each scale note, in clk cycles
//   - OCT_LOW/MID/HIGH    : octave encoding as seen on the octave output
//   - state_e             : tone FSM states
//   - half_period()       : octave-adjusted half-period for a note index
package buzzer_pkg;

  localparam int NOTE_W = 10;
  localparam int CNT_W  = 19;

  localparam logic [CNT_W-1:0] HP_DO  = 19'd191113;
  localparam logic [CNT_W-1:0] HP_RE  = 19'd170262;
  localparam logic [CNT_W-1:0] HP_MI  = 19'd151686;
  localparam logic [CNT_W-1:0] HP_FA  = 19'd143173;
  localparam logic [CNT_W-1:0] HP_SOL = 19'd127551;
  localparam logic [CNT_W-1:0] HP_LA  = 19'd113636;
  localparam logic [CNT_W-1:0] HP_TI  = 19'd101239;

  localparam logic [1:0] OCT_LOW  = 2'd0;
  localparam logic [1:0] OCT_MID  = 2'd1;
  localparam logic [1:0] OCT_HIGH = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  // idx: 1..7 = do..ti (0 returns 0, never loaded). Low doubles, high halves
  // with truncation; the low-octave do (382226) still fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] half_period(input logic [2:0] idx,
                                                   input logic [1:0] oct);
    logic [CNT_W-1:0] base;
    case (idx)
      3'd1:    base = HP_DO;
      3'd2:    base = HP_RE;
      3'd3:    base = HP_MI;
      3'd4:    base = HP_FA;
      3'd5:    base = HP_SOL;
      3'd6:    base = HP_LA;
      3'd7:    base = HP_TI;
      default: base = '0;
    endcase
    case (oct)
      OCT_LOW:  half_period = base << 1;
      OCT_HIGH: half_period = base >> 1;
      default:  half_period = base;
    endcase
  endfunction

endpackage

// File: rtl/note_deglitch.sv
// note_deglitch: accepts a synchronized vector only after it has held the
// same value for DEGLITCH_CYCLES consecutive cycles; shorter pulses vanish.
// Built only when TONE_DEGLITCH_EN is defined.
//   clk, rst : clock, synchronous active-high reset
//   din      : synchronized note vector
//   dout     : accepted (stable) note vector
`ifdef TONE_DEGLITCH_EN
module note_deglitch
  import buzzer_pkg::*;
#(
  parameter int DEGLITCH_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] din,
  output logic [NOTE_W-1:0] dout
);

  localparam int CW = $clog2(DEGLITCH_CYCLES + 1);
  localparam logic [CW:0] LIM = (CW + 1)'(DEGLITCH_CYCLES);

  logic [NOTE_W-1:0] prev_q, prev_d;
  logic [NOTE_W-1:0] out_q, out_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW:0]       held;

  // held = number of cycles din has shown its present value, counting this
  // one. cnt_q saturates at the limit, so held needs one extra bit.
  always_comb begin
    held   = (din == prev_q) ? ({1'b0, cnt_q} + 1'b1) : {{CW{1'b0}}, 1'b1};
    prev_d = din;
    cnt_d  = (held >= LIM) ? LIM[CW-1:0] : held[CW-1:0];
    out_d  = (held >= LIM) ? din : out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign dout = out_q;

endmodule
`endif

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: turns the 10-bit note vector into a square wave.
// Optional input deglitching is enabled by defining TONE_DEGLITCH_EN.
//   clk      : 100 MHz clock
//   rst      : synchronous active-high reset
//   note     : [6:0] do..ti, [7] low, [8] mid, [9] high octave (async)
//   buzzer   : square wave output
//   playing  : high while a tone sounds
//   note_idx : 0 = none, 1..7 = do..ti
//   octave   : 0 low, 1 mid, 2 high
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int DEGLITCH_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] note,
  output logic              buzzer,
  output logic              playing,
  output logic [2:0]        note_idx,
  output logic [1:0]        octave
);

  logic [NOTE_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NOTE_W-1:0] sel_vec;
  logic [2:0]        sel_note;
  logic [1:0]        sel_oct;
  logic [CNT_W-1:0]  sel_limit;

  state_e           state_q, state_d;
  logic             buzzer_q, buzzer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [2:0]       note_idx_q, note_idx_d;
  logic [1:0]       octave_q, octave_d;

  assign sync1_d = note;
  assign sync2_d = sync1_q;

`ifdef TONE_DEGLITCH_EN
  note_deglitch #(
    .DEGLITCH_CYCLES(DEGLITCH_CYCLES)
  ) u_deglitch (
    .clk  (clk),
    .rst  (rst),
    .din  (sync2_q),
    .dout (sel_vec)
  );
`else
  assign sel_vec = sync2_q;
  logic unused_deglitch;
  assign unused_deglitch = (DEGLITCH_CYCLES != 0);
`endif

  // Lowest set note bit wins (scan downward so the last hit is the lowest);
  // octave priority is high > low > mid, with mid as the fallback.
  always_comb begin
    sel_note = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (sel_vec[i]) sel_note = 3'(i + 1);
    end
    if (sel_vec[9])      sel_oct = OCT_HIGH;
    else if (sel_vec[7]) sel_oct = OCT_LOW;
    else                 sel_oct = OCT_MID;
    sel_limit = half_period(sel_note, sel_oct);
  end

  // Pitch reloads only at a toggle, so every half-period is whole and
  // pitch changes never glitch. Silence overrides the terminal count.
  always_comb begin
    state_d    = state_q;
    buzzer_d   = buzzer_q;
    cnt_d      = cnt_q;
    limit_d    = limit_q;
    note_idx_d = note_idx_q;
    octave_d   = octave_q;
    case (state_q)
      ST_IDLE: begin
        buzzer_d   = 1'b0;
        cnt_d      = '0;
        note_idx_d = 3'd0;
        if (sel_note != 3'd0) begin
          state_d    = ST_PLAY;
          buzzer_d   = 1'b1;
          limit_d    = sel_limit;
          note_idx_d = sel_note;
          octave_d   = sel_oct;
        end
      end
      ST_PLAY: begin
        if (sel_note == 3'd0) begin
          state_d    = ST_IDLE;
          buzzer_d   = 1'b0;
          cnt_d      = '0;
          note_idx_d = 3'd0;
        end else if (cnt_q == limit_q - 19'd1) begin
          buzzer_d   = ~buzzer_q;
          cnt_d      = '0;
          limit_d    = sel_limit;
          note_idx_d = sel_note;
          octave_d   = sel_oct;
        end else begin
          cnt_d = cnt_q + 19'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      state_q    <= ST_IDLE;
      buzzer_q   <= 1'b0;
      cnt_q      <= '0;
      limit_q    <= '0;
      note_idx_q <= 3'd0;
      octave_q   <= OCT_MID;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      buzzer_q   <= buzzer_d;
      cnt_q      <= cnt_d;
      limit_q    <= limit_d;
      note_idx_q <= note_idx_d;
      octave_q   <= octave_d;
    end
  end

  assign buzzer   = buzzer_q;
  assign playing  = (state_q == ST_PLAY);
  assign note_idx = note_idx_q;
  assign octave   = octave_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
module tb_buzzer_tone_gen;

`ifdef TONE_DEGLITCH_EN
  localparam int LAT = 11;   // 2 sync + 8 stable cycles + 1
`else
  localparam int LAT = 3;
`endif

  logic       clk;
  logic       rst;
  logic [9:0] note;
  logic       buzzer;
  logic       playing;
  logic [2:0] note_idx;
  logic [1:0] octave;

  int tests = 0;
  int fails = 0;

  // Reference half-periods for do..ti at the mid octave.
  int base_hp[7] = '{191113, 170262, 151686, 143173, 127551, 113636, 101239};

  buzzer_tone_gen #(
    .DEGLITCH_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .note     (note),
    .buzzer   (buzzer),
    .playing  (playing),
    .note_idx (note_idx),
    .octave   (octave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  // Advance n rising edges, landing 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: which note/octave the spec selects and its half-period.
  function automatic void model(input logic [9:0] v, output int idx,
                                output int oct, output int hp);
    idx = 0;
    for (int i = 0; i < 7; i++) if (v[i] && idx == 0) idx = i + 1;
    if (v[9])      oct = 2;
    else if (v[7]) oct = 0;
    else           oct = 1;
    if (idx == 0)      hp = 0;
    else if (oct == 0) hp = base_hp[idx-1] * 2;
    else if (oct == 2) hp = base_hp[idx-1] / 2;
    else               hp = base_hp[idx-1];
  endfunction

  // Go silent, then apply v and check the start of the tone at exact latency.
  task automatic play_case(input string tag, input logic [9:0] v);
    int idx, oct, hp;
    model(v, idx, oct, hp);
    note = 10'h000;
    step(LAT + 1);
    check({tag, "_idle_playing"}, 32'(playing), 32'd0);
    note = v;
    step(LAT - 1);
    check({tag, "_early_playing"}, 32'(playing), 32'd0);
    step(1);
    check({tag, "_playing"}, 32'(playing), 32'(idx != 0));
    check({tag, "_buzzer"}, 32'(buzzer), 32'(idx != 0));
    check({tag, "_note_idx"}, 32'(note_idx), 32'(idx));
    if (idx != 0) begin
      check({tag, "_octave"}, 32'(octave), 32'(oct));
      check({tag, "_limit"}, 32'(dut.limit_q), 32'(hp));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    logic [9:0] v;
    rst  = 1'b1;
    note = 10'h3FF;

    // Reset held 3 cycles with every input bit set.
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_buzzer", 32'(buzzer), 32'd0);
      check("rst_playing", 32'(playing), 32'd0);
      check("rst_note_idx", 32'(note_idx), 32'd0);
      check("rst_octave", 32'(octave), 32'd1);
    end
    rst  = 1'b0;
    note = 10'h000;
    step(2);

    // Directed selections.
    play_case("do_mid", 10'b01_0000_0001);
    play_case("do_high", 10'b10_0000_0001);
    play_case("do_low", 10'b00_1000_0001);
    play_case("priority", 10'h2D1);
    play_case("ti_high_mid", 10'h340);
    play_case("no_oct_fa", 10'h008);
    play_case("oct_only", 10'h380);

    // Randomized selections against the model.
    for (int i = 0; i < 40; i++) begin
      v = 10'($urandom_range(0, 1023));
      if (i % 8 == 7) v = v & 10'h380;
      play_case("rand", v);
    end

    // Reset during play, then restart after full latency.
    play_case("pre_rst", 10'h101);
    step(10);
    rst = 1'b1;
    step(1);
    check("midrst_buzzer", 32'(buzzer), 32'd0);
    check("midrst_playing", 32'(playing), 32'd0);
    check("midrst_note_idx", 32'(note_idx), 32'd0);
    check("midrst_octave", 32'(octave), 32'd1);
    rst = 1'b0;
    step(LAT - 1);
    check("postrst_early", 32'(playing), 32'd0);
    step(1);
    check("postrst_playing", 32'(playing), 32'd1);
    check("postrst_buzzer", 32'(buzzer), 32'd1);

    // Half-period length with a mid-half pitch change: ti high (50619)
    // must finish its half even though la high is selected at cycle 100.
    play_case("ti_high", 10'h240);
    n = 0;
    while (buzzer === 1'b1 && n < 60000) begin
      step(1);
      n++;
      if (n == 100) note = 10'h220;
    end
    check("half_period_len", 32'(n), 32'd50619);
    check("toggle_buzzer", 32'(buzzer), 32'd0);
    check("toggle_note_idx", 32'(note_idx), 32'd6);
    check("toggle_octave", 32'(octave), 32'd2);
    check("toggle_limit", 32'(dut.limit_q), 32'd56818);

    // Silence mid-half: outputs clear exactly LAT edges later.
    step(200);
    check("pre_clear_buzzer", 32'(buzzer), 32'd0);
    note = 10'h000;
    step(LAT - 1);
    check("clear_early_playing", 32'(playing), 32'd1);
    step(1);
    check("clear_playing", 32'(playing), 32'd0);
    check("clear_buzzer", 32'(buzzer), 32'd0);
    check("clear_note_idx", 32'(note_idx), 32'd0);

`ifdef TONE_DEGLITCH_EN
    // A 5-cycle pulse is ignored; a 9-cycle pulse is accepted.
    step(20);
    note = 10'h101;
    step(5);
    note = 10'h000;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (playing === 1'b1) n++;
    end
    check("short_pulse_ignored", 32'(n), 32'd0);
    note = 10'h101;
    step(9);
    note = 10'h000;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (playing === 1'b1) n++;
    end
    check("long_pulse_accepted", 32'(n != 0), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
